// File: rtl/code_lock_fsm.sv
// Digit-entry code lock.
// The user strobes CODE_LEN digits per attempt. The lock does not reveal
// which digit was wrong: every attempt consumes the full digit count before
// it reports OPEN or CLOSED. After MAX_FAILS consecutive failures the lock
// goes to LOCKOUT and ignores all input for LOCKOUT_CYCLES clocks.
module code_lock_fsm #(
    parameter int DIGIT_W        = 4,
    parameter int CODE_LEN       = 6,
    parameter logic [DIGIT_W*CODE_LEN-1:0] CODE = {4'h4, 4'h8, 4'h3, 4'h8, 4'h1, 4'h5},
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DIGIT_W-1:0]                digit_in,
    input  logic                              digit_valid,
    input  logic                              clear,
    output logic                              open,
    output logic                              closed,
    output logic                              locked,
    output logic [$clog2(CODE_LEN+1)-1:0]     digit_cnt,
    output logic [3:0]                        fail_cnt
);

    localparam int CNT_W = $clog2(CODE_LEN + 1);
    localparam int LK_W  = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(CODE_LEN - 1);
    localparam logic [3:0]       FAIL_MAX  = 4'(MAX_FAILS);
    localparam logic [LK_W-1:0]  LOCK_LOAD = LK_W'(LOCKOUT_CYCLES);

    typedef enum logic [1:0] {
        S_ENTRY   = 2'd0,
        S_OPEN    = 2'd1,
        S_CLOSED  = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_mismatch;
    logic [LK_W-1:0]   r_lock_cnt;
    logic              r_open;
    logic              r_closed;
    logic              r_locked;
    logic [CNT_W-1:0]  r_digit_cnt;
    logic [3:0]        r_fail_cnt;

    logic [CNT_W-1:0]  w_idx;
    logic              w_mm_acc;
    logic              w_last;
    logic [3:0]        w_fail_inc;

    // Expected digit for a position; position 0 is the most significant digit.
    function automatic logic [DIGIT_W-1:0] code_digit(input logic [CNT_W-1:0] idx);
        logic [DIGIT_W-1:0] v;
        v = '0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (CNT_W'(i) == idx) begin
                v = CODE[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
            end
        end
        return v;
    endfunction

    // Evaluate the strobed digit: position, accumulated mismatch, last-digit and saturating fail count.
    always_comb begin
        w_idx      = '0;
        w_mm_acc   = 1'b0;
        w_last     = 1'b0;
        w_fail_inc = r_fail_cnt;
        // A strobe in OPEN or CLOSED starts a fresh attempt at position 0.
        if (r_state == S_ENTRY) begin
            w_idx    = r_digit_cnt;
            w_mm_acc = r_mismatch | (digit_in != code_digit(r_digit_cnt));
        end else begin
            w_idx    = '0;
            w_mm_acc = (digit_in != code_digit('0));
        end
        w_last = (w_idx == LAST_IDX);
        if (r_fail_cnt >= FAIL_MAX) begin
            w_fail_inc = FAIL_MAX;
        end else begin
            w_fail_inc = r_fail_cnt + 4'd1;
        end
    end

    // Lock state machine with registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_ENTRY;
            r_mismatch  <= 1'b0;
            r_lock_cnt  <= '0;
            r_open      <= 1'b0;
            r_closed    <= 1'b0;
            r_locked    <= 1'b0;
            r_digit_cnt <= '0;
            r_fail_cnt  <= 4'd0;
        end else begin
            case (r_state)
                S_LOCKOUT: begin
                    // Inputs are ignored; leave after exactly LOCKOUT_CYCLES clocks.
                    if (r_lock_cnt <= LK_W'(1)) begin
                        r_state     <= S_ENTRY;
                        r_lock_cnt  <= '0;
                        r_locked    <= 1'b0;
                        r_fail_cnt  <= 4'd0;
                        r_digit_cnt <= '0;
                        r_mismatch  <= 1'b0;
                    end else begin
                        r_lock_cnt <= r_lock_cnt - LK_W'(1);
                    end
                end
                S_ENTRY, S_OPEN, S_CLOSED: begin
                    if (clear) begin
                        // Abort wins over a simultaneous digit; no failure is counted.
                        r_state     <= S_ENTRY;
                        r_digit_cnt <= '0;
                        r_mismatch  <= 1'b0;
                        r_open      <= 1'b0;
                        r_closed    <= 1'b0;
                    end else if (digit_valid) begin
                        r_open   <= 1'b0;
                        r_closed <= 1'b0;
                        if (w_last) begin
                            r_digit_cnt <= '0;
                            r_mismatch  <= 1'b0;
                            if (!w_mm_acc) begin
                                r_state    <= S_OPEN;
                                r_open     <= 1'b1;
                                r_fail_cnt <= 4'd0;
                            end else if (w_fail_inc == FAIL_MAX) begin
                                r_state    <= S_LOCKOUT;
                                r_locked   <= 1'b1;
                                r_fail_cnt <= FAIL_MAX;
                                r_lock_cnt <= LOCK_LOAD;
                            end else begin
                                r_state    <= S_CLOSED;
                                r_closed   <= 1'b1;
                                r_fail_cnt <= w_fail_inc;
                            end
                        end else begin
                            r_state     <= S_ENTRY;
                            r_digit_cnt <= w_idx + CNT_W'(1);
                            r_mismatch  <= w_mm_acc;
                        end
                    end else begin
                        r_state <= r_state;
                    end
                end
                default: begin
                    r_state     <= S_ENTRY;
                    r_mismatch  <= 1'b0;
                    r_lock_cnt  <= '0;
                    r_open      <= 1'b0;
                    r_closed    <= 1'b0;
                    r_locked    <= 1'b0;
                    r_digit_cnt <= '0;
                end
            endcase
        end
    end

    assign open      = r_open;
    assign closed    = r_closed;
    assign locked    = r_locked;
    assign digit_cnt = r_digit_cnt;
    assign fail_cnt  = r_fail_cnt;

endmodule
